// File: rtl/fp_tile_arb_pkg.sv
// Shared types and the round-robin picker for the FP tile arbiter.
// Tags travel alongside adder operations to steer results back.
package fp_tile_arb_pkg;

  localparam int N_PORTS = 4;

  typedef enum logic [1:0] {
    ARB,
    OPA,
    OPB
  } arb_state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] port;
    logic       last;
  } tag_t;

  // Returns {found, index}; the lowest offset from ptr wins.
  function automatic logic [2:0] rr_pick(
    input logic [N_PORTS-1:0] elig,
    input logic [1:0]         ptr
  );
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (elig[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_arb_out_fifo.sv
// Per-port result buffer; output is read from the storage flops,
// so data stays stable until popped.
module fp_arb_out_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         nonempty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          full;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign nonempty = (cnt != '0);
  assign rdata    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  // Upstream credits must make this unreachable.
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr && full));

endmodule

// File: rtl/fp_tile_arbiter.sv
// Shares one pipelined FP adder among four stream ports, with
// round-robin grants and credit-protected per-port result FIFOs.
module fp_tile_arbiter
  import fp_tile_arb_pkg::*;
#(
  parameter int BW        = 32,
  parameter int BWB       = BW / 8,
  parameter int LATENCY   = 11,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk_line,
  input  logic              clk_line_rst_high,
  input  logic [3:0]        stream_in_TVALID,
  output logic [3:0]        stream_in_TREADY,
  input  logic [4*BW-1:0]   stream_in_TDATA,
  input  logic [4*BWB-1:0]  stream_in_TKEEP,
  input  logic [3:0]        stream_in_TLAST,
  output logic [3:0]        stream_out_TVALID,
  input  logic [3:0]        stream_out_TREADY,
  output logic [4*BW-1:0]   stream_out_TDATA,
  output logic [4*BWB-1:0]  stream_out_TKEEP,
  output logic [3:0]        stream_out_TLAST,
  output logic              fpu_op_valid,
  output logic [BW-1:0]     fpu_op_a,
  output logic [BW-1:0]     fpu_op_b,
  input  logic              fpu_res_valid,
  input  logic [BW-1:0]     fpu_res_data,
  output logic              err_tag_mismatch
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  logic clk;
  logic rst;
  assign clk = clk_line;
  assign rst = clk_line_rst_high;

  arb_state_t state, state_d;
  logic [1:0]  gnt, gnt_d, rr_ptr;
  logic [2:0]  pick;
  logic        grant_now, a_hs, b_hs;
  logic [3:0]  elig, out_hs;
  logic [BW-1:0] a_q, in_data;
  logic [CW-1:0] credit [N_PORTS];
  tag_t        op_tag;
  tag_t        pipe [LATENCY];
  tag_t        tag_out;
  logic        unused_keep;

  assign unused_keep      = ^stream_in_TKEEP;
  assign stream_out_TKEEP = '1;
  assign out_hs  = stream_out_TVALID & stream_out_TREADY;
  assign in_data = stream_in_TDATA[int'(gnt)*BW +: BW];
  assign a_hs    = (state == OPA) && stream_in_TVALID[gnt];
  assign b_hs    = (state == OPB) && stream_in_TVALID[gnt];
  assign tag_out = pipe[LATENCY-1];

  always_comb begin
    for (int p = 0; p < N_PORTS; p++)
      elig[p] = stream_in_TVALID[p] && (credit[p] != '0);
  end

  assign pick = rr_pick(elig, rr_ptr);

  always_comb begin
    state_d          = state;
    gnt_d            = gnt;
    grant_now        = 1'b0;
    stream_in_TREADY = '0;
    unique case (state)
      ARB: begin
        if (pick[2]) begin
          gnt_d     = pick[1:0];
          grant_now = 1'b1;
          state_d   = OPA;
        end
      end
      OPA: begin
        stream_in_TREADY[gnt] = 1'b1;
        if (stream_in_TVALID[gnt]) state_d = OPB;
      end
      OPB: begin
        stream_in_TREADY[gnt] = 1'b1;
        if (stream_in_TVALID[gnt]) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      gnt   <= '0;
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr           <= '0;
      a_q              <= '0;
      fpu_op_valid     <= 1'b0;
      fpu_op_a         <= '0;
      fpu_op_b         <= '0;
      op_tag           <= '0;
      err_tag_mismatch <= 1'b0;
    end else begin
      fpu_op_valid <= b_hs;
      op_tag <= '{vld: b_hs, port: gnt, last: stream_in_TLAST[gnt]};
      if (a_hs) a_q <= in_data;
      if (b_hs) begin
        fpu_op_a <= a_q;
        fpu_op_b <= in_data;
        rr_ptr   <= gnt + 2'd1;
      end
      if (tag_out.vld != fpu_res_valid) err_tag_mismatch <= 1'b1;
    end
  end

  // Tag enters alongside fpu_op_valid so the last stage meets fpu_res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= op_tag;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (rst) credit[p] <= CW'(OUT_DEPTH);
      else credit[p] <= credit[p] + CW'(out_hs[p])
                      - CW'(grant_now && (gnt_d == 2'(p)));
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_out
    fp_arb_out_fifo #(
      .W     (BW + 1),
      .DEPTH (OUT_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr       (tag_out.vld && (tag_out.port == 2'(p))),
      .wdata    ({tag_out.last, fpu_res_data}),
      .rd       (out_hs[p]),
      .rdata    ({stream_out_TLAST[p], stream_out_TDATA[p*BW +: BW]}),
      .nonempty (stream_out_TVALID[p])
    );
  end

endmodule

// File: tb/tb_fp_tile_arbiter.sv
// Directed bench for fp_tile_arbiter with a behavioural pipelined adder
// and per-port expected-result queues.
module tb_fp_tile_arbiter;

  localparam int BW  = 32;
  localparam int BWB = 4;
  localparam int LAT = 11;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;
  localparam logic [31:0] F5 = 32'h40A00000;
  localparam logic [31:0] F6 = 32'h40C00000;
  localparam logic [31:0] F7 = 32'h40E00000;

  logic clk = 0;
  logic rst = 1;
  logic [3:0]       in_valid = '0;
  logic [3:0]       in_ready;
  logic [4*BW-1:0]  in_data = '0;
  logic [4*BWB-1:0] in_keep = '0;
  logic [3:0]       in_last = '0;
  logic [3:0]       out_valid;
  logic [3:0]       out_rdy = '0;
  logic [4*BW-1:0]  out_data;
  logic [4*BWB-1:0] out_keep;
  logic [3:0]       out_last;
  logic             op_valid;
  logic [31:0]      op_a, op_b;
  logic             res_valid;
  logic [31:0]      res_data;
  logic             err;
  logic             inject = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] d; logic last; logic isb;} beat_t;
  typedef struct {logic [31:0] d; logic last;} res_t;

  beat_t inq [4][$];
  res_t  expq [4][$];
  int    glog [$];
  int    gcnt [4];
  logic [3:0] bdone, aseen;

  fp_tile_arbiter #(
    .BW(BW), .BWB(BWB), .LATENCY(LAT), .OUT_DEPTH(4)
  ) dut (
    .clk_line          (clk),
    .clk_line_rst_high (rst),
    .stream_in_TVALID  (in_valid),
    .stream_in_TREADY  (in_ready),
    .stream_in_TDATA   (in_data),
    .stream_in_TKEEP   (in_keep),
    .stream_in_TLAST   (in_last),
    .stream_out_TVALID (out_valid),
    .stream_out_TREADY (out_rdy),
    .stream_out_TDATA  (out_data),
    .stream_out_TKEEP  (out_keep),
    .stream_out_TLAST  (out_last),
    .fpu_op_valid      (op_valid),
    .fpu_op_a          (op_a),
    .fpu_op_b          (op_b),
    .fpu_res_valid     (res_valid),
    .fpu_res_data      (res_data),
    .err_tag_mismatch  (err)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == '0) d = {x[31], 63'b0};
    else d = {x[31], 11'(x[30:23]) - 11'd127 + 11'd1023, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'b0};
    return {d[63], 8'(d[62:52] - 11'd1023 + 11'd127), d[51:29]};
  endfunction

  logic        pv [LAT];
  logic [31:0] pd [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= op_valid;
      pd[0] <= r2f(f2r(op_a) + f2r(op_b));
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign res_valid = pv[LAT-1] | inject;
  assign res_data  = pd[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 4; p++) begin
      if (inq[p].size() > 0) begin
        in_valid[p] = 1'b1;
        in_data[p*BW +: BW] = inq[p][0].d;
        in_last[p] = inq[p][0].last;
      end else begin
        in_valid[p] = 1'b0;
      end
    end
  endtask

  task automatic send(input int p, input logic [31:0] a,
                      input logic [31:0] b, input logic last,
                      input logic [31:0] exp);
    beat_t ba, bb;
    res_t  r;
    ba = '{d: a, last: 1'b0, isb: 1'b0};
    bb = '{d: b, last: last, isb: 1'b1};
    r  = '{d: exp, last: last};
    inq[p].push_back(ba);
    inq[p].push_back(bb);
    expq[p].push_back(r);
    drive();
  endtask

  task automatic tick();
    logic [3:0] ih, oh;
    res_t r;
    ih = in_valid & in_ready;
    oh = out_valid & out_rdy;
    if (!rst) begin
      chk("tready_onehot", 64'($countones(in_ready) <= 1), 1);
      for (int p = 0; p < 4; p++) begin
        if (oh[p]) begin
          chk($sformatf("out%0d_expected", p), 64'(expq[p].size() != 0), 1);
          if (expq[p].size() != 0) begin
            r = expq[p].pop_front();
            chk($sformatf("out%0d_data", p), 64'(out_data[p*BW +: BW]), 64'(r.d));
            chk($sformatf("out%0d_last", p), 64'(out_last[p]), 64'(r.last));
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int p = 0; p < 4; p++) begin
        if (ih[p] && inq[p].size() > 0) begin
          if (inq[p][0].isb) begin
            glog.push_back(p);
            gcnt[p]++;
            bdone[p] = 1'b1;
          end else begin
            aseen[p] = 1'b1;
          end
          void'(inq[p].pop_front());
        end
      end
    end
    drive();
  endtask

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < 4; p++) n += inq[p].size() + expq[p].size();
    return n;
  endfunction

  task automatic clear_all();
    for (int p = 0; p < 4; p++) begin
      inq[p].delete();
      expq[p].delete();
      gcnt[p] = 0;
    end
    glog.delete();
    bdone = '0;
    aseen = '0;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (pending() > 0 && n < 500) begin
      tick();
      n++;
    end
    chk(tag, 64'(pending()), 0);
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    chk("rst_tready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_op_valid", 64'(op_valid), 0);
    chk("rst_op_a", 64'(op_a), 0);
    chk("rst_op_b", 64'(op_b), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_tkeep", 64'(out_keep), 64'hFFFF);

    // Single pair on port 0, latency check
    out_rdy = 4'b1110;
    send(0, F1, F2, 1'b1, F3);
    n = 0;
    while (!bdone[0] && n < 50) begin
      tick();
      n++;
    end
    chk("t1_b_handshake", 64'(bdone[0]), 1);
    repeat (LAT) tick();
    chk("t1_not_yet", 64'(out_valid[0]), 0);
    tick();
    chk("t1_valid_at_13", 64'(out_valid[0]), 1);
    chk("t1_data", 64'(out_data[31:0]), 64'h40400000);
    chk("t1_last", 64'(out_last[0]), 1);
    tick();
    chk("t1_data_hold", 64'(out_data[31:0]), 64'h40400000);
    out_rdy = 4'b1111;
    drain("t1_drain");

    // All four ports, round-robin order
    do_reset();
    out_rdy = 4'b1111;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 4; p++) send(p, F1, F1, k[0], F2);
    drain("t2_drain");
    chk("t2_glen", 64'(glog.size()), 8);
    chk("t2_g0", 64'(glog[0]), 0);
    chk("t2_g1", 64'(glog[1]), 1);
    chk("t2_g2", 64'(glog[2]), 2);
    chk("t2_g3", 64'(glog[3]), 3);
    chk("t2_g4", 64'(glog[4]), 0);

    // Port 2 backpressured
    do_reset();
    out_rdy = 4'b1011;
    send(2, F1, F1, 1'b0, F2);
    send(2, F2, F1, 1'b1, F3);
    send(2, F3, F1, 1'b0, F4);
    send(2, F4, F1, 1'b1, F5);
    send(2, F5, F1, 1'b0, F6);
    send(2, F6, F1, 1'b1, F7);
    for (int k = 0; k < 3; k++) begin
      send(0, F1, F1, 1'b1, F2);
      send(1, F1, F2, 1'b0, F3);
      send(3, F2, F2, 1'b1, F4);
    end
    repeat (150) tick();
    chk("t3_p2_grants", 64'(gcnt[2]), 4);
    chk("t3_p0_done", 64'(expq[0].size()), 0);
    chk("t3_p1_done", 64'(expq[1].size()), 0);
    chk("t3_p3_done", 64'(expq[3].size()), 0);
    chk("t3_p2_credit", 64'(dut.credit[2]), 0);
    chk("t3_p2_held", 64'(out_valid[2]), 1);
    out_rdy = 4'b1111;
    drain("t3_drain");
    chk("t3_p2_total", 64'(gcnt[2]), 6);

    // Reset while in OPB
    do_reset();
    out_rdy = 4'b1111;
    send(0, F1, F2, 1'b1, F3);
    n = 0;
    while (!aseen[0] && n < 50) begin
      tick();
      n++;
    end
    chk("t4_a_seen", 64'(aseen[0]), 1);
    rst = 1'b1;
    clear_all();
    tick();
    chk("t4_tready", 64'(in_ready), 0);
    for (int p = 0; p < 4; p++)
      chk($sformatf("t4_credit%0d", p), 64'(dut.credit[p]), 4);
    chk("t4_fifo_empty", 64'(out_valid), 0);
    rst = 1'b0;
    send(0, F2, F3, 1'b0, F5);
    drain("t4_drain");

    // Spurious adder result
    chk("t5_err_before", 64'(err), 0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("t5_err_rise", 64'(err), 1);
    repeat (5) tick();
    chk("t5_err_sticky", 64'(err), 1);
    do_reset();
    chk("t5_err_cleared", 64'(err), 0);

    // Same-cycle grant and pop on port 1 at credit 1
    out_rdy = 4'b1101;
    send(1, F1, F2, 1'b0, F3);
    send(1, F2, F2, 1'b1, F4);
    send(1, F3, F4, 1'b0, F7);
    repeat (40) tick();
    chk("t6_credit_low", 64'(dut.credit[1]), 1);
    chk("t6_out_held", 64'(out_valid[1]), 1);
    send(1, F1, F1, 1'b1, F2);
    out_rdy = 4'b1111;
    tick();
    chk("t6_credit_same", 64'(dut.credit[1]), 1);
    drain("t6_drain");
    chk("t6_credit_final", 64'(dut.credit[1]), 4);
    chk("t6_err", 64'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
